// File: rtl/instr_encoder.sv
// instr_encoder
//   Write-side counterpart of the instruction decoder. Structured instruction records arrive
//   over a valid/ready stream. Each record is packed into the 16-bit instruction format and
//   written to consecutive IMEM words, starting from a base address. Illegal records and
//   address overflow end the session in an error state.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start_i           begin a session at base_addr_i (honoured in idle/error only)
//   base_addr_i       first IMEM word address of the session
//   in_valid_i/in_ready_o   record handshake; ready only while loading
//   in_kind_i         0 ALU_IMM, 1 ALU, 2 REG_MEM, 3 JUMP_IMM, 4 JUMP_REG, 5 BRANCH
//   in_func_i         ALU func / reg-mem func (LOAD 0, STORE 1, GET 2, PUT 3, SET 4)
//   in_cond_i         branch condition
//   in_reg_i          register address
//   in_imm_i          address immediate, or data immediate in [7:0]
//   in_last_i         final record of the session
//   imem_we_o/imem_addr_o/imem_wdata_o   IMEM write port, one cycle after acceptance
//   busy_o            session in progress (not idle)
//   done_o            one-cycle pulse with the last word's write
//   count_o           words written this session
//   err_o/err_code_o  sticky error; code 1 illegal record, 2 address overflow
module instr_encoder #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            in_kind_i,
    input  logic [3:0]            in_func_i,
    input  logic [2:0]            in_cond_i,
    input  logic [3:0]            in_reg_i,
    input  logic [11:0]           in_imm_i,
    input  logic                  in_last_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [15:0]           imem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

    localparam logic [2:0] KindAluImm  = 3'd0;
    localparam logic [2:0] KindAlu     = 3'd1;
    localparam logic [2:0] KindRegMem  = 3'd2;
    localparam logic [2:0] KindJumpImm = 3'd3;
    localparam logic [2:0] KindJumpReg = 3'd4;
    localparam logic [2:0] KindBranch  = 3'd5;

    localparam logic [3:0] FuncSet = 4'd4;

    localparam logic [1:0] ErrIllegal  = 2'd1;
    localparam logic [1:0] ErrOverflow = 2'd2;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             wdata_q;
    logic                    err_q;
    logic [1:0]              err_code_q;

    logic                    accept;
    logic                    start_load;
    logic                    at_top;
    logic                    illegal;
    logic [15:0]             enc;

    assign accept     = in_valid_i && (state_q == StLoad);
    assign start_load = start_i && ((state_q == StIdle) || (state_q == StError));
    // Writing the last IMEM word of a non-final record leaves nowhere for the next one.
    assign at_top     = &wr_addr_q;

    // Pack the record; bit 0 is the branch flag, [3:1] the opcode or condition.
    always_comb begin
        illegal = 1'b0;
        enc     = '0;
        case (in_kind_i)
            KindAluImm: begin
                enc     = {in_imm_i[7:0], in_func_i, 3'b000, 1'b0};
                illegal = |in_imm_i[11:8];
            end
            KindAlu: enc = {4'h0, in_reg_i, in_func_i, 3'b001, 1'b0};
            KindRegMem: begin
                if (in_func_i == FuncSet) begin
                    // SET carries a data immediate in place of the register field.
                    enc     = {in_imm_i[7:0], in_func_i, 3'b010, 1'b0};
                    illegal = |in_imm_i[11:8];
                end else begin
                    enc     = {4'h0, in_reg_i, in_func_i, 3'b010, 1'b0};
                    illegal = in_func_i > FuncSet;
                end
            end
            KindJumpImm: enc = {in_imm_i, 3'b100, 1'b0};
            KindJumpReg: enc = {12'h000, 3'b111, 1'b0};
            KindBranch:  enc = {in_imm_i, in_cond_i, 1'b1};
            default:     illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_i) state_d = StLoad;
            end
            StLoad: begin
                if (accept) begin
                    if (illegal)        state_d = StError;
                    else if (in_last_i) state_d = StDone;
                    else if (at_top)    state_d = StError;
                end
            end
            StDone:  state_d = StIdle;
            StError: begin
                if (start_i) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_addr_q  <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= accept && !illegal;
            if (start_load) begin
                wr_addr_q  <= base_addr_i;
                count_q    <= '0;
                err_q      <= 1'b0;
                err_code_q <= '0;
            end else if (accept && !illegal) begin
                addr_q    <= wr_addr_q;
                wdata_q   <= enc;
                wr_addr_q <= wr_addr_q + 1'b1;
                count_q   <= count_q + 1'b1;
                if (!in_last_i && at_top) begin
                    err_q      <= 1'b1;
                    err_code_q <= ErrOverflow;
                end
            end else if (accept) begin
                err_q      <= 1'b1;
                err_code_q <= ErrIllegal;
            end
        end
    end

    assign in_ready_o   = (state_q == StLoad);
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign count_o      = count_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: expected IMEM writes are queued as records are driven and
// popped as the DUT produces writes.
module tb_instr_encoder;

    localparam int unsigned AW = 12;

    localparam logic [2:0] KAluImm  = 3'd0;
    localparam logic [2:0] KAlu     = 3'd1;
    localparam logic [2:0] KRegMem  = 3'd2;
    localparam logic [2:0] KJumpImm = 3'd3;
    localparam logic [2:0] KJumpReg = 3'd4;
    localparam logic [2:0] KBranch  = 3'd5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [2:0]    in_kind_i;
    logic [3:0]    in_func_i;
    logic [2:0]    in_cond_i;
    logic [3:0]    in_reg_i;
    logic [11:0]   in_imm_i;
    logic          in_last_i;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [15:0]   imem_wdata_o;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   count_o;
    logic          err_o;
    logic [1:0]    err_code_o;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_kind_i(in_kind_i),
        .in_func_i(in_func_i), .in_cond_i(in_cond_i), .in_reg_i(in_reg_i),
        .in_imm_i(in_imm_i), .in_last_i(in_last_i), .imem_we_o(imem_we_o),
        .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o), .busy_o(busy_o),
        .done_o(done_o), .count_o(count_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    // One stimulus cycle plus the write it should produce one cycle later.
    typedef struct packed {
        logic          st;
        logic          v;
        logic [2:0]    kind;
        logic [3:0]    func;
        logic [2:0]    cond;
        logic [3:0]    rg;
        logic [11:0]   imm;
        logic          last;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [15:0]   exp_data;
    } item_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input item_t it);
        start_i    = it.st;
        in_valid_i = it.v;
        in_kind_i  = it.kind;
        in_func_i  = it.func;
        in_cond_i  = it.cond;
        in_reg_i   = it.rg;
        in_imm_i   = it.imm;
        in_last_i  = it.last;
        if (it.exp_we) sb.push_back('{it.exp_addr, it.exp_data});
    endtask

    task automatic start_session(input logic [AW-1:0] base);
        start_i     = 1'b1;
        base_addr_i = base;
        in_valid_i  = 1'b0;
        step();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; in_valid_i = 1'b1;
        repeat (3) step();
        checks++;
        if ({in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, done_o, count_o, err_o,
             err_code_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%h wdata=%h done=%b cnt=%0d err=%b code=%0d, required all 0",
                     in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, done_o, count_o, err_o,
                     err_code_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, required 0", busy_o);
        end
        rst = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_start_ignored: busy got %b, required 0", busy_o);
        end
    endtask

    task automatic test_basic();
        item_t items [2];
        wr_t   exp;
        items = '{
            '{1'b0, 1'b1, KAluImm, 4'd3, 3'd0, 4'd0, 12'h0A5, 1'b0, 1'b1, 12'h010, 16'hA530},
            '{1'b0, 1'b1, KBranch, 4'd0, 3'd5, 4'd0, 12'h123, 1'b1, 1'b1, 12'h011, 16'h123B}};
        start_session(12'h010);
        for (int i = 0; i < $size(items); i++) begin
            drive(items[i]);
            step();
            if (imem_we_o === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL basic_write: got %h:%h, required no write", imem_addr_o, imem_wdata_o);
                end else begin
                    exp = sb.pop_front();
                    if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                        errors++;
                        $display("FAIL basic_write: got %h:%h, required %h:%h", imem_addr_o, imem_wdata_o, exp.addr, exp.data);
                    end
                end
            end
        end
        checks++;
        if ({done_o, busy_o, count_o} !== {1'b1, 1'b1, 13'd2}) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b cnt=%0d, required 1 1 2", done_o, busy_o, count_o);
        end
        in_valid_i = 1'b0;
        step();
        checks++;
        if ({done_o, busy_o, imem_we_o, count_o} !== {1'b0, 1'b0, 1'b0, 13'd2}) begin
            errors++;
            $display("FAIL basic_idle: got done=%b busy=%b we=%b cnt=%0d, required 0 0 0 2", done_o, busy_o, imem_we_o, count_o);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL basic_missing: got %0d writes missing, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        item_t items [8];
        wr_t   exp;
        items = '{
            '{1'b0, 1'b1, KRegMem,  4'd1, 3'd0, 4'd7, 12'h000, 1'b0, 1'b1, 12'h100, 16'h0714},
            '{1'b0, 1'b1, KRegMem,  4'd4, 3'd0, 4'd9, 12'h03C, 1'b0, 1'b1, 12'h101, 16'h3C44},
            '{1'b0, 1'b1, KJumpReg, 4'hF, 3'd7, 4'hF, 12'hFFF, 1'b0, 1'b1, 12'h102, 16'h000E},
            '{1'b0, 1'b1, KAlu,     4'hA, 3'd0, 4'd5, 12'hFFF, 1'b0, 1'b1, 12'h103, 16'h05A2},
            '{1'b0, 1'b1, KRegMem,  4'd2, 3'd0, 4'd3, 12'h000, 1'b0, 1'b1, 12'h104, 16'h0324},
            '{1'b0, 1'b1, KRegMem,  4'd3, 3'd0, 4'hF, 12'h000, 1'b0, 1'b1, 12'h105, 16'h0F34},
            '{1'b0, 1'b1, KRegMem,  4'd0, 3'd0, 4'd1, 12'h000, 1'b0, 1'b1, 12'h106, 16'h0104},
            '{1'b0, 1'b1, KJumpImm, 4'd0, 3'd0, 4'd0, 12'hFFF, 1'b1, 1'b1, 12'h107, 16'hFFF8}};
        start_session(12'h100);
        for (int i = 0; i < $size(items); i++) begin
            drive(items[i]);
            step();
            checks++;
            if (imem_we_o !== 1'b1) begin
                errors++; $display("FAIL b2b_strobe[%0d]: got we=%b, required 1", i, imem_we_o);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_write: got %h:%h, required no write", imem_addr_o, imem_wdata_o);
            end else begin
                exp = sb.pop_front();
                if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                    errors++;
                    $display("FAIL b2b_write[%0d]: got %h:%h, required %h:%h", i, imem_addr_o, imem_wdata_o, exp.addr, exp.data);
                end
            end
        end
        checks++;
        if ({done_o, count_o} !== {1'b1, 13'd8}) begin
            errors++; $display("FAIL b2b_count: got done=%b cnt=%0d, required 1 8", done_o, count_o);
        end
        in_valid_i = 1'b0;
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL b2b_missing: got %0d writes missing, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_illegal();
        item_t items [3];
        wr_t   exp;
        items = '{
            '{1'b0, 1'b1, KAlu,    4'd2, 3'd0, 4'd1, 12'h000, 1'b0, 1'b1, 12'h200, 16'h0122},
            '{1'b0, 1'b1, KRegMem, 4'd5, 3'd0, 4'd3, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000},
            '{1'b0, 1'b1, KAlu,    4'd1, 3'd0, 4'd1, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000}};
        start_session(12'h200);
        for (int i = 0; i < $size(items); i++) begin
            drive(items[i]);
            step();
            if (imem_we_o === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL illegal_write: got %h:%h, required no write", imem_addr_o, imem_wdata_o);
                end else begin
                    exp = sb.pop_front();
                    if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                        errors++;
                        $display("FAIL illegal_write: got %h:%h, required %h:%h", imem_addr_o, imem_wdata_o, exp.addr, exp.data);
                    end
                end
            end
        end
        checks++;
        if ({err_o, err_code_o, in_ready_o, busy_o, count_o} !== {1'b1, 2'd1, 1'b0, 1'b1, 13'd1}) begin
            errors++;
            $display("FAIL illegal_state: got err=%b code=%0d ready=%b busy=%b cnt=%0d, required 1 1 0 1 1",
                     err_o, err_code_o, in_ready_o, busy_o, count_o);
        end
        start_session(12'h300);
        checks++;
        if ({err_o, err_code_o, count_o, in_ready_o} !== {1'b0, 2'd0, 13'd0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_restart: got err=%b code=%0d cnt=%0d ready=%b, required 0 0 0 1",
                     err_o, err_code_o, count_o, in_ready_o);
        end
        drive('{1'b0, 1'b1, KJumpImm, 4'd0, 3'd0, 4'd0, 12'h456, 1'b1, 1'b1, 12'h300, 16'h4568});
        step();
        checks++;
        if (imem_we_o !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL illegal_newbase: got we=%b, required 1", imem_we_o);
        end else begin
            exp = sb.pop_front();
            if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                errors++;
                $display("FAIL illegal_newbase: got %h:%h, required %h:%h", imem_addr_o, imem_wdata_o, exp.addr, exp.data);
            end
        end
        in_valid_i = 1'b0;
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL illegal_missing: got %0d writes missing, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_illegal_kinds();
        item_t items [4];
        items = '{
            '{1'b0, 1'b1, 3'd6,    4'd0, 3'd0, 4'd0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000},
            '{1'b0, 1'b1, 3'd7,    4'd0, 3'd0, 4'd0, 12'h000, 1'b1, 1'b0, 12'h000, 16'h0000},
            '{1'b0, 1'b1, KAluImm, 4'd2, 3'd0, 4'd0, 12'h1A5, 1'b0, 1'b0, 12'h000, 16'h0000},
            '{1'b0, 1'b1, KRegMem, 4'd4, 3'd0, 4'd0, 12'h13C, 1'b0, 1'b0, 12'h000, 16'h0000}};
        for (int i = 0; i < $size(items); i++) begin
            start_session(12'h050);
            drive(items[i]);
            step();
            checks++;
            if ({imem_we_o, err_o, err_code_o, count_o, in_ready_o} !==
                {1'b0, 1'b1, 2'd1, 13'd0, 1'b0}) begin
                errors++;
                $display("FAIL illegal_kind[%0d]: got we=%b err=%b code=%0d cnt=%0d ready=%b, required 0 1 1 0 0",
                         i, imem_we_o, err_o, err_code_o, count_o, in_ready_o);
            end
            in_valid_i = 1'b0;
        end
    endtask

    task automatic test_overflow();
        item_t items [3];
        wr_t   exp;
        items = '{
            '{1'b0, 1'b1, KAluImm, 4'd0, 3'd0, 4'd0, 12'h011, 1'b0, 1'b1, 12'hFFE, 16'h1100},
            '{1'b0, 1'b1, KAluImm, 4'd1, 3'd0, 4'd0, 12'h022, 1'b0, 1'b1, 12'hFFF, 16'h2210},
            '{1'b0, 1'b1, KAluImm, 4'd2, 3'd0, 4'd0, 12'h033, 1'b0, 1'b0, 12'h000, 16'h0000}};
        start_session(12'hFFE);
        for (int i = 0; i < $size(items); i++) begin
            drive(items[i]);
            step();
            if (imem_we_o === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL overflow_write: got %h:%h, required no write", imem_addr_o, imem_wdata_o);
                end else begin
                    exp = sb.pop_front();
                    if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                        errors++;
                        $display("FAIL overflow_write: got %h:%h, required %h:%h", imem_addr_o, imem_wdata_o, exp.addr, exp.data);
                    end
                end
            end
        end
        checks++;
        if ({err_o, err_code_o, count_o, in_ready_o} !== {1'b1, 2'd2, 13'd2, 1'b0}) begin
            errors++;
            $display("FAIL overflow_state: got err=%b code=%0d cnt=%0d ready=%b, required 1 2 2 0",
                     err_o, err_code_o, count_o, in_ready_o);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL overflow_missing: got %0d writes missing, required 0", sb.size()); sb.delete();
        end
        // A last record on the top word is a clean finish.
        start_session(12'hFFF);
        drive('{1'b0, 1'b1, KJumpReg, 4'd0, 3'd0, 4'd0, 12'h000, 1'b1, 1'b1, 12'hFFF, 16'h000E});
        step();
        checks++;
        if (imem_we_o !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL top_last_write: got we=%b, required 1", imem_we_o);
        end else begin
            exp = sb.pop_front();
            if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                errors++;
                $display("FAIL top_last_write: got %h:%h, required %h:%h", imem_addr_o, imem_wdata_o, exp.addr, exp.data);
            end
        end
        checks++;
        if ({done_o, err_o, err_code_o, count_o} !== {1'b1, 1'b0, 2'd0, 13'd1}) begin
            errors++;
            $display("FAIL top_last_done: got done=%b err=%b code=%0d cnt=%0d, required 1 0 0 1",
                     done_o, err_o, err_code_o, count_o);
        end
        in_valid_i = 1'b0;
        step();
    endtask

    task automatic test_start_ignored();
        item_t items [3];
        wr_t   exp;
        items = '{
            '{1'b0, 1'b1, KAlu,     4'd1, 3'd0, 4'd2, 12'h000, 1'b0, 1'b1, 12'h040, 16'h0212},
            '{1'b1, 1'b1, KAluImm,  4'd4, 3'd0, 4'd0, 12'h05A, 1'b0, 1'b1, 12'h041, 16'h5A40},
            '{1'b1, 1'b1, KJumpImm, 4'd0, 3'd0, 4'd0, 12'h010, 1'b1, 1'b1, 12'h042, 16'h0108}};
        start_session(12'h040);
        base_addr_i = 12'h999;
        for (int i = 0; i < $size(items); i++) begin
            drive(items[i]);
            step();
            checks++;
            if (imem_we_o !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL start_ignored_strobe[%0d]: got we=%b, required 1", i, imem_we_o);
            end else begin
                exp = sb.pop_front();
                if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                    errors++;
                    $display("FAIL start_ignored_write[%0d]: got %h:%h, required %h:%h", i, imem_addr_o, imem_wdata_o, exp.addr, exp.data);
                end
            end
        end
        checks++;
        if ({done_o, count_o, err_o} !== {1'b1, 13'd3, 1'b0}) begin
            errors++;
            $display("FAIL start_ignored_count: got done=%b cnt=%0d err=%b, required 1 3 0", done_o, count_o, err_o);
        end
        // start_i during the done cycle is ignored too.
        in_valid_i = 1'b0;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if ({busy_o, count_o} !== {1'b0, 13'd3}) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b cnt=%0d, required 0 3", busy_o, count_o);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL start_ignored_missing: got %0d writes missing, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        wr_t exp;
        start_session(12'h020);
        drive('{1'b0, 1'b1, KAluImm, 4'd2, 3'd0, 4'd0, 12'h077, 1'b0, 1'b1, 12'h020, 16'h7720});
        step();
        checks++;
        if (imem_we_o !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL reset_mid_first: got we=%b, required 1", imem_we_o);
        end else begin
            exp = sb.pop_front();
            if ({imem_addr_o, imem_wdata_o} !== {exp.addr, exp.data}) begin
                errors++;
                $display("FAIL reset_mid_first: got %h:%h, required %h:%h", imem_addr_o, imem_wdata_o, exp.addr, exp.data);
            end
        end
        // Second record is accepted in the same cycle reset arrives; its write must not appear.
        drive('{1'b0, 1'b1, KAluImm, 4'd3, 3'd0, 4'd0, 12'h088, 1'b0, 1'b0, 12'h000, 16'h0000});
        rst = 1'b1;
        step();
        checks++;
        if ({imem_we_o, imem_addr_o, imem_wdata_o, busy_o, done_o, count_o, err_o, err_code_o,
             in_ready_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got we=%b addr=%h wdata=%h busy=%b done=%b cnt=%0d err=%b code=%0d ready=%b, required all 0",
                     imem_we_o, imem_addr_o, imem_wdata_o, busy_o, done_o, count_o, err_o,
                     err_code_o, in_ready_o);
        end
        rst = 1'b0;
        in_valid_i = 1'b0;
        step();
        checks++;
        if ({imem_we_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_after: got we=%b busy=%b, required 0 0", imem_we_o, busy_o);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; in_valid_i = 1'b0;
        in_kind_i = '0; in_func_i = '0; in_cond_i = '0; in_reg_i = '0;
        in_imm_i = '0; in_last_i = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_illegal_kinds();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
